// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared state type, error word and parameter defaults for the memory arbiter
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam logic [31:0] ARB_ERR_DATA   = 32'hDEAD_BEEF;
    localparam int          ARB_TIMEOUT    = 16;
    localparam int          ARB_STARVE_MAX = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, data and shared memory port bundle for the memory arbiter
interface mem_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    logic        stall_f;
    logic        stall_m;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wd, mem_ack, mem_rdata,
        output if_ack, if_rdata, dm_ack, dm_rdata, stall_f, stall_m,
               mem_req, mem_we, mem_addr, mem_wd, err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wd, mem_ack, mem_rdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata, stall_f, stall_m,
               mem_req, mem_we, mem_addr, mem_wd, err
    );

endinterface

// File: rtl/arb_wdog.sv
// rtl/arb_wdog.sv - grant-to-ack watchdog counter; expire flags the last permitted busy cycle
module arb_wdog
    import mips_pkg::*;
#(
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [7:0] wd_cnt_q;
    logic [7:0] wd_cnt_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (clr) begin
            wd_cnt_d = '0;
        end else if (en) begin
            wd_cnt_d = wd_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign expire = (wd_cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates fetch and data requests onto one shared memory port
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int TIMEOUT    = ARB_TIMEOUT,
    parameter int STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t  state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wd_q, mem_wd_d;
    logic        if_ack_q, if_ack_d;
    logic        dm_ack_q, dm_ack_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        err_q, err_d;
    logic [3:0]  starve_q, starve_d;
    logic        grant;
    logic        fetch_prio;
    logic        wd_expire;

    arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (grant),
        .en     ((state_q != IDLE) && !bus.mem_ack),
        .expire (wd_expire)
    );

    // A starved fetch only preempts data when it is actually requesting.
    assign fetch_prio = bus.if_req && (starve_q == STARVE_LIM);

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        starve_d   = starve_q;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;
        err_d      = 1'b0;
        grant      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.dm_req && !fetch_prio) begin
                    grant      = 1'b1;
                    state_d    = BUSY_D;
                    mem_req_d  = 1'b1;
                    mem_we_d   = bus.dm_we;
                    mem_addr_d = bus.dm_addr;
                    mem_wd_d   = bus.dm_wd;
                    if (bus.if_req && (starve_q < STARVE_LIM)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (bus.if_req) begin
                    grant      = 1'b1;
                    state_d    = BUSY_I;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = bus.if_addr;
                    starve_d   = '0;
                end
            end
            BUSY_I: begin
                if (bus.mem_ack || wd_expire) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    err_d      = !bus.mem_ack;
                    if_rdata_d = bus.mem_ack ? bus.mem_rdata : ARB_ERR_DATA;
                end
            end
            BUSY_D: begin
                // mem_ack wins over a simultaneous watchdog expiry.
                if (bus.mem_ack || wd_expire) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    dm_ack_d  = 1'b1;
                    err_d     = !bus.mem_ack;
                    if (!mem_we_q) begin
                        dm_rdata_d = bus.mem_ack ? bus.mem_rdata : ARB_ERR_DATA;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            err_q      <= 1'b0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            if_ack_q   <= if_ack_d;
            dm_ack_q   <= dm_ack_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            err_q      <= err_d;
            starve_q   <= starve_d;
        end
    end

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_wd   = mem_wd_q;
    assign bus.if_ack   = if_ack_q;
    assign bus.dm_ack   = dm_ack_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.dm_rdata = dm_rdata_q;
    assign bus.err      = err_q;
    assign bus.stall_f  = bus.if_req && !if_ack_q;
    assign bus.stall_m  = bus.dm_req && !dm_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector and corner-case bench for mem_arbiter
module tb_mem_arbiter;
    import mips_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ifr;
        logic [31:0] ifa;
        logic        dmr;
        logic        dwe;
        logic [31:0] dma;
        logic [31:0] dwd;
        logic        mack;
        logic [31:0] mrd;
        logic        e_mreq;
        logic        e_mwe;
        logic [31:0] e_maddr;
        logic [31:0] e_mwd;
        logic        e_ifack;
        logic        e_dmack;
        logic        e_err;
        logic        e_stf;
        logic        e_stm;
        logic [31:0] e_ifrd;
        logic [31:0] e_dmrd;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_wd     = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
    endtask

    initial begin
        int dacks;
        int dacks_before_if;
        int ifacks;
        int overlap;
        int ack_cyc;
        int errs;
        int held_bad;
        int late;

        errors = 0;
        checks = 0;
        rst    = 1'b1;
        idle_inputs();

        // rst ifr ifa | dmr dwe dma dwd | mack mrd || mreq mwe maddr mwd | ifack dmack err stf stm | ifrd dmrd
        vecs[0]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 32'h0,
                     1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 32'h0,
                     1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0};
        vecs[2]  = '{1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 32'h0,
                     1'b1, 1'b0, 32'h40,  32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0};
        vecs[3]  = '{1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,         1'b1, 32'h2008_0005,
                     1'b1, 1'b0, 32'h40,  32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0};
        vecs[4]  = '{1'b0, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,         1'b1, 32'h2008_0005,
                     1'b0, 1'b0, 32'h40,  32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2008_0005, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 32'h0,
                     1'b0, 1'b0, 32'h40,  32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2008_0005, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 32'h44, 1'b1, 1'b1, 32'h100, 32'hA5A5_A5A5, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h40,  32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2008_0005, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 32'h44, 1'b1, 1'b1, 32'h100, 32'hA5A5_A5A5, 1'b1, 32'hFFFF_FFFF,
                     1'b1, 1'b1, 32'h100, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2008_0005, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 32'h0,
                     1'b0, 1'b0, 32'h100, 32'hA5A5_A5A5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h2008_0005, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0,   32'h0,         1'b1, 32'h8C0A_0000,
                     1'b1, 1'b0, 32'h44,  32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2008_0005, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 32'h0,
                     1'b0, 1'b0, 32'h44,  32'hA5A5_A5A5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8C0A_0000, 32'h0};

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst           = vecs[i].rst;
            bus.if_req    = vecs[i].ifr;
            bus.if_addr   = vecs[i].ifa;
            bus.dm_req    = vecs[i].dmr;
            bus.dm_we     = vecs[i].dwe;
            bus.dm_addr   = vecs[i].dma;
            bus.dm_wd     = vecs[i].dwd;
            bus.mem_ack   = vecs[i].mack;
            bus.mem_rdata = vecs[i].mrd;
            #1;
            chk1 ($sformatf("r%0d mem_req", i),  bus.mem_req,  vecs[i].e_mreq);
            chk1 ($sformatf("r%0d mem_we", i),   bus.mem_we,   vecs[i].e_mwe);
            chk32($sformatf("r%0d mem_addr", i), bus.mem_addr, vecs[i].e_maddr);
            chk32($sformatf("r%0d mem_wd", i),   bus.mem_wd,   vecs[i].e_mwd);
            chk1 ($sformatf("r%0d if_ack", i),   bus.if_ack,   vecs[i].e_ifack);
            chk1 ($sformatf("r%0d dm_ack", i),   bus.dm_ack,   vecs[i].e_dmack);
            chk1 ($sformatf("r%0d err", i),      bus.err,      vecs[i].e_err);
            chk1 ($sformatf("r%0d stall_f", i),  bus.stall_f,  vecs[i].e_stf);
            chk1 ($sformatf("r%0d stall_m", i),  bus.stall_m,  vecs[i].e_stm);
            chk32($sformatf("r%0d if_rdata", i), bus.if_rdata, vecs[i].e_ifrd);
            chk32($sformatf("r%0d dm_rdata", i), bus.dm_rdata, vecs[i].e_dmrd);
        end

        // Starvation: data held with back-to-back loads while fetch waits.
        @(negedge clk);
        idle_inputs();
        bus.dm_req  = 1'b1;
        bus.dm_addr = 32'h200;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h80;
        dacks = 0;
        dacks_before_if = -1;
        ifacks = 0;
        overlap = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            #1;
            bus.mem_ack   = bus.mem_req;
            bus.mem_rdata = 32'h0000_1000;
            if (bus.if_ack && bus.dm_ack) overlap++;
            if (bus.dm_ack) begin
                dacks++;
                if (dacks == 5) bus.dm_req = 1'b0;
            end
            if (bus.if_ack) begin
                ifacks++;
                if (ifacks == 1) dacks_before_if = dacks;
                bus.if_req = 1'b0;
            end
        end
        chkn("starve data_acks_before_fetch", dacks_before_if, 4);
        chkn("starve total_data_acks", dacks, 5);
        chkn("starve fetch_acks", ifacks, 1);
        chkn("starve ack_overlap", overlap, 0);
        chkn("starve cnt_after", int'(dut.starve_q), 0);

        // Load that memory never acknowledges.
        @(negedge clk);
        idle_inputs();
        bus.dm_req  = 1'b1;
        bus.dm_addr = 32'h300;
        ack_cyc = -1;
        errs = 0;
        held_bad = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            #1;
            if (bus.err) errs++;
            if (bus.dm_ack && ack_cyc < 0) begin
                ack_cyc = c;
                chk32("timeout dm_rdata", bus.dm_rdata, ARB_ERR_DATA);
                chk1 ("timeout err_with_ack", bus.err, 1'b1);
                chk1 ("timeout mem_req_dropped", bus.mem_req, 1'b0);
                chk1 ("timeout stall_m", bus.stall_m, 1'b0);
                bus.dm_req = 1'b0;
            end else if (ack_cyc < 0 && (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h300)) begin
                held_bad++;
            end
        end
        chkn("timeout ack_cycle", ack_cyc, 17);
        chkn("timeout err_pulses", errs, 1);
        chkn("timeout mem_held", held_bad, 0);

        // mem_ack lands on the last watchdog cycle.
        @(negedge clk);
        idle_inputs();
        bus.dm_req  = 1'b1;
        bus.dm_addr = 32'h304;
        ack_cyc = -1;
        errs = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            bus.mem_ack   = (c == 16);
            bus.mem_rdata = 32'h1234_5678;
            #1;
            if (bus.err) errs++;
            if (bus.dm_ack && ack_cyc < 0) begin
                ack_cyc = c;
                chk32("lastcyc dm_rdata", bus.dm_rdata, 32'h1234_5678);
                bus.dm_req = 1'b0;
            end
        end
        chkn("lastcyc ack_cycle", ack_cyc, 17);
        chkn("lastcyc err_pulses", errs, 0);

        // Reset during the second BUSY_D cycle.
        @(negedge clk);
        idle_inputs();
        bus.dm_req  = 1'b1;
        bus.dm_addr = 32'h400;
        bus.dm_wd   = 32'h5555_0000;
        @(negedge clk);
        #1;
        chk1("rstbusy mem_req_before", bus.mem_req, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk1 ("rstbusy mem_req", bus.mem_req, 1'b0);
        chk1 ("rstbusy mem_we", bus.mem_we, 1'b0);
        chk32("rstbusy mem_addr", bus.mem_addr, 32'h0);
        chk32("rstbusy mem_wd", bus.mem_wd, 32'h0);
        chk1 ("rstbusy dm_ack", bus.dm_ack, 1'b0);
        chk1 ("rstbusy if_ack", bus.if_ack, 1'b0);
        chk1 ("rstbusy err", bus.err, 1'b0);
        chk32("rstbusy dm_rdata", bus.dm_rdata, 32'h0);
        chk32("rstbusy if_rdata", bus.if_rdata, 32'h0);
        rst = 1'b0;
        bus.dm_req = 1'b0;
        late = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (bus.dm_ack || bus.err || bus.mem_req) late++;
        end
        chkn("rstbusy no_late_activity", late, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, 16, max cycles from grant to mem_ack before abort; range 2..255.
REQ-002 Parameter STARVE_MAX, 4, consecutive fetch losses before fetch is forced to win; range 1..15.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 if_req  in  1  fetch request; held with if_addr stable until if_ack.
REQ-006 if_addr  in  32  fetch word address (pc_current).
REQ-007 if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-008 if_rdata  out  32  registered instruction word.
REQ-009 dm_req  in  1  data request; held with dm_addr/dm_we/dm_wd stable until dm_ack.
REQ-010 dm_we  in  1  1 = store, 0 = load.
REQ-011 dm_addr  in  32  data address (alu_out).
REQ-012 dm_wd  in  32  store data.
REQ-013 dm_ack  out  1  one-cycle pulse: data access complete.
REQ-014 dm_rdata  out  32  registered load data.
REQ-015 stall_f  out  1  combinational: if_req high and if_ack low.
REQ-016 stall_m  out  1  combinational: dm_req high and dm_ack low.
REQ-017 mem_req, mem_we  out  1 each  request and write-enable to the single shared memory port.
REQ-018 mem_addr, mem_wd  out  32 each  registered address and write data to memory.
REQ-019 mem_ack  in  1  memory completion strobe; mem_rdata valid in the same cycle.
REQ-020 mem_rdata  in  32  memory read data.
REQ-021 err  out  1  one-cycle pulse on timeout abort.

Function
REQ-022 FSM states: IDLE, BUSY_I, BUSY_D.
REQ-023 IDLE: dm_req wins unless starve_cnt == STARVE_MAX and if_req is high; the winner's address/data/we registered onto mem_* and mem_req=1 next cycle; state becomes BUSY_D or BUSY_I.
REQ-024 IDLE with neither request: stay IDLE, mem_req=0.
REQ-025 starve_cnt (4 bits) increments when both requests are high in IDLE and data wins; clears when fetch is granted; saturates at STARVE_MAX.
REQ-026 BUSY_x: mem_req, mem_addr, mem_we, mem_wd held constant until mem_ack.
REQ-027 On mem_ack in BUSY_x: mem_req=0 next cycle, requester ack pulses next cycle, rdata register loads mem_rdata (loads and fetches only; stores leave dm_rdata unchanged), state returns to IDLE.
REQ-028 Minimum latency req-to-ack: 3 cycles (grant, memory with same-cycle mem_ack, ack); no back-to-back grant, IDLE always occupies at least one cycle between transactions.
REQ-029 wd_cnt (8 bits) clears on grant, increments each BUSY cycle without mem_ack; when wd_cnt == TIMEOUT-1 without mem_ack: err pulses, requester acks with rdata = 32'hDEAD_BEEF (store: rdata unchanged), mem_req drops, state returns to IDLE.
REQ-030 mem_ack in the same cycle as timeout: mem_ack takes precedence, no err.
REQ-031 mem_ack while IDLE is ignored.
REQ-032 Requests dropped before ack: protocol violation; transaction still completes and acks.
REQ-033 if_ack and dm_ack are never high in the same cycle.

Reset
REQ-034 On rst: state IDLE; mem_req, mem_we, if_ack, dm_ack, err = 0; mem_addr, mem_wd, if_rdata, dm_rdata = 0; starve_cnt, wd_cnt = 0.
REQ-035 rst during BUSY aborts without ack or err; mem_req is 0 the cycle after rst is sampled.

Structure
REQ-036 Shared package mips_pkg holds the arb_state_t enum, ARB_ERR_DATA = 32'hDEAD_BEEF, and the TIMEOUT/STARVE_MAX defaults.
REQ-037 The watchdog counter is one sub-module, arb_wdog (clear, enable, expire output); all other logic is in mem_arbiter.

Verification
REQ-038 if_req with if_addr 0x0000_0040, memory acks 1 cycle after mem_req with 0x2008_0005 -> if_ack in cycle 3, if_rdata = 0x2008_0005, stall_f low after ack.
REQ-039 if_req and dm_req both high, dm_we=1, dm_addr 0x100, dm_wd 0xA5A5_A5A5 -> store issued first with mem_we=1, dm_ack, then fetch granted.
REQ-040 dm_req held continuously with 5 back-to-back loads while if_req is high -> fetch granted after exactly 4 data grants (STARVE_MAX=4), starve_cnt returns to 0.
REQ-041 Memory never acks a load -> err pulses and dm_ack with dm_rdata = 0xDEAD_BEEF at 16 cycles after grant.
REQ-042 rst asserted during the second cycle of BUSY_D -> no dm_ack, no err, mem_req=0 next cycle, all outputs at reset values.
REQ-043 mem_ack on the final watchdog cycle with 0x1234_5678 -> normal ack, rdata 0x1234_5678, err stays 0.
